// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating branch counters indexed by PC word bits.
// Combinational prediction read, registered update with misprediction pulse and counter.
module branch_pht #(
    parameter int INDEX_BITS = 4,
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    output logic [1:0]       pred_state,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            pht_q [ENTRIES];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_next;
    logic                  upd_miss;

    assign pred_idx   = pred_pc[INDEX_BITS+1:2];
    assign upd_idx    = upd_pc[INDEX_BITS+1:2];
    assign pred_state = pht_q[pred_idx];
    assign pred_taken = pred_state[1];
    assign upd_cur    = pht_q[upd_idx];
    assign upd_miss   = upd_valid && (upd_taken != upd_cur[1]);

    // Tag-less table: PC bits outside the index are intentionally dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[XLEN-1:INDEX_BITS+2], upd_pc[1:0]};

    always_comb begin
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
            mispredict     <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            if (upd_valid) begin
                pht_q[upd_idx] <= upd_next;
            end
            mispredict <= upd_miss;
            if (upd_miss && !(&mispredict_cnt)) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_pht.sv
// Randomized and directed check of branch_pht against an array-of-integers counter model.
module tb_branch_pht;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        mispredict;
    logic [15:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int mdl [16];
    int mdl_cnt;
    int mdl_mp;

    branch_pht #(.INDEX_BITS(4), .XLEN(32), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .pred_state    (pred_state),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; leaves at the next posedge+1 with inputs still held.
    task automatic do_cycle(input logic r, input logic [31:0] ppc, input logic uv,
                            input logic [31:0] upc, input logic ut);
        int pi;
        int ui;
        rst       = r;
        pred_pc   = ppc;
        upd_valid = uv;
        upd_pc    = upc;
        upd_taken = ut;
        pi = pc_idx(ppc);
        ui = pc_idx(upc);
        #1;
        check("pred_state_pre", 32'(pred_state), 32'(mdl[pi]));
        check("pred_taken_pre", 32'(pred_taken), 32'(mdl[pi] >= 2));
        if (r) begin
            for (int i = 0; i < 16; i++) mdl[i] = 1;
            mdl_mp  = 0;
            mdl_cnt = 0;
        end else begin
            mdl_mp = (uv && (int'(ut) != int'(mdl[ui] >= 2))) ? 1 : 0;
            if (mdl_mp == 1 && mdl_cnt < 65535) mdl_cnt++;
            if (uv) begin
                if (ut) mdl[ui] = (mdl[ui] < 3) ? mdl[ui] + 1 : 3;
                else    mdl[ui] = (mdl[ui] > 0) ? mdl[ui] - 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        check("mispredict", 32'(mispredict), 32'(mdl_mp));
        check("mispredict_cnt", 32'(mispredict_cnt), 32'(mdl_cnt));
        check("pred_state_post", 32'(pred_state), 32'(mdl[pi]));
    endtask

    initial begin
        rst       = 1'b1;
        pred_pc   = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 1;
        mdl_cnt = 0;
        mdl_mp  = 0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset sweep over every index, no updates.
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, 32'(i * 4), 1'b0, 32'h0, 1'b0);
            check("reset_state", 32'(pred_state), 32'h1);
        end

        // Saturate up at 0x40.
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b1);
        check("sat_up_state", 32'(pred_state), 32'h3);
        check("sat_up_cnt", 32'(mispredict_cnt), 32'h1);

        // Saturate down with hysteresis.
        do_cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b0);
        check("hyst_taken", 32'(pred_taken), 32'h1);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b0);
        check("sat_down_state", 32'(pred_state), 32'h0);
        check("sat_down_cnt", 32'(mispredict_cnt), 32'h3);

        // Aliasing and isolation.
        do_cycle(1'b0, 32'h44, 1'b1, 32'h44, 1'b1);
        do_cycle(1'b0, 32'h48, 1'b1, 32'h44, 1'b1);
        check("iso_48", 32'(pred_state), 32'h1);
        do_cycle(1'b0, 32'h84, 1'b0, 32'h0, 1'b0);
        check("alias_84", 32'(pred_state), 32'h3);

        // Same-cycle read and update of 0x10 from WNT.
        do_cycle(1'b0, 32'h10, 1'b1, 32'h10, 1'b1);
        check("same_cycle_next", 32'(pred_state), 32'h2);

        // Reset colliding with an update to a counter at ST.
        do_cycle(1'b0, 32'h44, 1'b0, 32'h0, 1'b0);
        check("pre_rst_state", 32'(pred_state), 32'h3);
        do_cycle(1'b1, 32'h44, 1'b1, 32'h44, 1'b0);
        rst = 1'b0;
        check("rst_mid_state", 32'(pred_state), 32'h1);
        check("rst_mid_cnt", 32'(mispredict_cnt), 32'h0);

        // Random traffic, upper PC bits randomized to exercise aliasing.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'b0, $urandom, ($urandom_range(0, 3) != 0), $urandom,
                     1'($urandom_range(0, 1)));
        end
        // Hammer a few indices to exercise back-to-back saturation.
        for (int i = 0; i < 200; i++) begin
            do_cycle(1'b0, 32'($urandom_range(0, 3) * 4), 1'b1,
                     32'($urandom_range(0, 3) * 4) | ($urandom & 32'hFFFF_FFC0),
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_pht.md
# branch_pht

- Pattern history table of 2-bit saturating branch counters, one per entry, indexed by PC bits.
- Sits downstream of the single-counter FSM: it replicates that counter per table entry and exposes a prediction to fetch.
- Sits upstream of fetch redirect: it accepts resolved-branch updates from execute.
- It flags and counts mispredictions for performance monitoring.

## Interface

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries).
- XLEN, 32, PC width.
- CNT_W, 16, width of the misprediction counter.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  reset, synchronous and active-high.
- pred_pc  input  XLEN  fetch PC to predict.
- pred_taken  output  1  prediction for pred_pc (counter MSB).
- pred_state  output  2  raw counter value for pred_pc.
- upd_valid  input  1  resolved-branch update strobe.
- upd_pc  input  XLEN  PC of the resolved branch.
- upd_taken  input  1  actual outcome (1 = taken).
- mispredict  output  1  registered one-cycle pulse: the last update disagreed with the counter MSB.
- mispredict_cnt  output  CNT_W  saturating count of mispredicted updates.

## Operation

- Index = pc[INDEX_BITS+1:2]; bits [1:0] are ignored, since instructions are word aligned. PCs differing only above the index bits alias to the same entry, with no tag.
- Counter encoding:
  - 00 strongly not-taken (SNT)
  - 01 weakly not-taken (WNT)
  - 10 weakly taken (WT)
  - 11 strongly taken (ST)
- Transitions when upd_valid=1:
  - upd_taken=1: SNT→WNT→WT→ST, and ST stays ST.
  - upd_taken=0: ST→WT→WNT→SNT, and SNT stays SNT.
  - Saturation is required; the counter never wraps.
- upd_valid=0: no entry changes.
- Only the indexed entry changes; all other entries hold.
- Prediction path is combinational from table state: pred_state = table[index(pred_pc)] and pred_taken = pred_state[1].
- Misprediction on an update is upd_taken != table[index(upd_pc)][1], evaluated with the pre-update value.
- mispredict is a registered copy of that comparison ANDed with upd_valid.
- mispredict_cnt increments by 1 on each mispredicting update and saturates at 2^CNT_W−1.
- Reset values:
  - every table entry = 01 (WNT), so pred_taken=0 and pred_state=01 for any PC after reset
  - mispredict = 0
  - mispredict_cnt = 0
- Reset mid-operation: rst=1 on a clock edge has priority over a simultaneous upd_valid. The update is discarded, the table is re-initialised to WNT, and both counters clear.

## Timing

- Prediction has zero latency: pred_taken follows pred_pc in the same cycle.
- An update sampled at edge N is visible on pred_state from just after edge N.
- Same-cycle read and update of the same index: pred_state shows the pre-update value (no bypass). The new value appears the following cycle.
- mispredict is asserted for exactly the cycle after the update edge; back-to-back mispredicting updates hold it high continuously.
- mispredict_cnt updates at the same edge that sets mispredict.
- Back-to-back updates to the same index on consecutive cycles each step the counter once; no update is lost.
- Reset takes effect at the first rising edge with rst=1. Outputs hold reset values while rst stays high.

## Test plan

- Reset: hold rst=1 for 2 cycles, release, then sweep pred_pc over indices 0..15. Required: pred_state=01 and pred_taken=0 for every index; mispredict_cnt=0.
- Saturate up: 4 consecutive updates upd_pc=0x40, upd_taken=1. Required:
  - pred_state for pred_pc=0x40 goes 10, 11, 11, 11
  - mispredict pulses only after the first update
  - mispredict_cnt=1
- Saturate down and hysteresis, from ST at 0x40:
  - 1 update taken=0: state 10, pred_taken still 1, mispredict=1.
  - 2 more updates taken=0: state 01 then 00.
  - Further updates taken=0: state holds at 00.
  - Required final mispredict_cnt=3 (1 + 1 + 1).
- Aliasing/isolation: update 0x44 ×2 taken. Required:
  - 0x44 reads 11
  - 0x48 stays 01
  - 0x84 (same index as 0x44, 0x84[5:2]=0001) reads 11
- Same-cycle read and update: pred_pc=upd_pc=0x10 from WNT with upd_taken=1. Required: pred_state=01 in that cycle and 10 the next cycle.
- Reset mid-stream: assert rst in the same cycle as upd_valid=1 to a counter at 11 with upd_taken=0. Required next cycle: entry=01, mispredict=0, mispredict_cnt=0.
